// File: rtl/game_round_scheduler.sv
// Round sequencer for the pad-reaction game: gap, pseudo-random target pick,
// timed reaction window, score/miss bookkeeping and game-over signalling.
module game_round_scheduler #(
  parameter int NUM_PADS   = 3,
  parameter int TICK_DIV   = 50000,
  parameter int GAP_MS     = 250,
  parameter int REACT_MS   = 1000,
  parameter int MAX_MISSES = 3
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic [NUM_PADS-1:0] pad_hit,
  output logic [NUM_PADS-1:0] light_onehot,
  output logic [15:0]         score,
  output logic [3:0]          misses,
  output logic                game_over,
  output logic                busy,
  output logic [2:0]          state_out
);

  localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MS_MAX = (GAP_MS > REACT_MS) ? GAP_MS : REACT_MS;
  localparam int MW     = $clog2(MS_MAX + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [MW-1:0] GAP_LAST   = MW'(GAP_MS - 1);
  localparam logic [MW-1:0] GAP_END    = MW'(GAP_MS);
  localparam logic [MW-1:0] REACT_LAST = MW'(REACT_MS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    GAP  = 3'd1,
    ARM  = 3'd2,
    WAIT = 3'd3,
    HIT  = 3'd4,
    MISS = 3'd5,
    OVER = 3'd6
  } state_t;

  state_t              state;
  logic [7:0]          lfsr;
  logic [2:0]          prev_tgt;
  logic [NUM_PADS-1:0] pad_q;
  logic [PW-1:0]       presc;
  logic [MW-1:0]       ms;

  logic                tick;
  logic                gap_done;
  logic                react_done;
  logic                count_en;
  logic [NUM_PADS-1:0] rise;
  logic                hit_tgt;
  logic                hit_wrong;
  logic [2:0]          cand;
  logic [2:0]          tgt_next;

  always_comb begin
    tick       = (presc == PRESC_LAST);
    // Once the gap has expired the ms counter parks at GAP_END while pads are held.
    gap_done   = (ms == GAP_END) || (tick && ms == GAP_LAST);
    react_done = tick && (ms == REACT_LAST);
    count_en   = (state == GAP && ms != GAP_END) || (state == WAIT);
    rise       = pad_hit & ~pad_q;
    // While in WAIT the light register is exactly the target mask.
    hit_tgt    = |(rise & light_onehot);
    hit_wrong  = |(rise & ~light_onehot);
    cand       = 3'(lfsr % NUM_PADS);
    if (cand == prev_tgt)
      tgt_next = (cand == 3'(NUM_PADS - 1)) ? 3'd0 : cand + 3'd1;
    else
      tgt_next = cand;
  end

  assign busy      = !(state == IDLE || state == OVER);
  assign state_out = state;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      lfsr         <= 8'hA5;
      prev_tgt     <= '0;
      pad_q        <= '0;
      presc        <= '0;
      ms           <= '0;
      light_onehot <= '0;
      score        <= '0;
      misses       <= '0;
      game_over    <= '0;
    end else begin
      pad_q <= pad_hit;
      lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

      if (count_en) begin
        if (tick) begin
          presc <= '0;
          ms    <= ms + 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end

      // Transitions into GAP or WAIT below override the counter update above.
      case (state)
        IDLE, OVER: begin
          if (start) begin
            score     <= '0;
            misses    <= '0;
            game_over <= 1'b0;
            presc     <= '0;
            ms        <= '0;
            state     <= GAP;
          end
        end
        GAP: begin
          if (gap_done && pad_hit == '0) state <= ARM;
        end
        ARM: begin
          prev_tgt     <= tgt_next;
          light_onehot <= NUM_PADS'(1) << tgt_next;
          presc        <= '0;
          ms           <= '0;
          state        <= WAIT;
        end
        WAIT: begin
          if (hit_tgt) begin
            light_onehot <= '0;
            score        <= (score == 16'hFFFF) ? score : score + 16'd1;
            state        <= HIT;
          end else if (hit_wrong || react_done) begin
            light_onehot <= '0;
            misses       <= misses + 4'd1;
            state        <= MISS;
          end
        end
        HIT: begin
          presc <= '0;
          ms    <= '0;
          state <= GAP;
        end
        MISS: begin
          if (misses == 4'(MAX_MISSES)) begin
            game_over <= 1'b1;
            state     <= OVER;
          end else begin
            presc <= '0;
            ms    <= '0;
            state <= GAP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_scheduler.sv
// Directed bench for game_round_scheduler with a small tick divider so that
// whole rounds, timeouts and a full game fit in a short run.
module tb_game_round_scheduler;

  logic        clock;
  logic        resetn;
  logic        start;
  logic [2:0]  pad_hit;
  logic [2:0]  light_onehot;
  logic [15:0] score;
  logic [3:0]  misses;
  logic        game_over;
  logic        busy;
  logic [2:0]  state_out;

  int checks = 0;
  int errors = 0;
  logic [2:0]  prev_light;
  logic [15:0] exp_score;

  game_round_scheduler #(
    .NUM_PADS(3), .TICK_DIV(4), .GAP_MS(2), .REACT_MS(5), .MAX_MISSES(3)
  ) dut (
    .clock(clock), .resetn(resetn), .start(start), .pad_hit(pad_hit),
    .light_onehot(light_onehot), .score(score), .misses(misses),
    .game_over(game_over), .busy(busy), .state_out(state_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_to_wait();
    int n;
    n = 0;
    while (state_out !== 3'd3 && n < 100) begin
      step();
      n++;
    end
    check("reach_wait", {29'd0, state_out}, 32'd3);
  endtask

  function automatic logic [2:0] rot(input logic [2:0] l);
    return {l[1:0], l[2]};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, {29'd0, state_out}, 32'd0);
    check({tag, "_light"}, {29'd0, light_onehot}, 32'd0);
    check({tag, "_score"}, {16'd0, score}, 32'd0);
    check({tag, "_misses"}, {28'd0, misses}, 32'd0);
    check({tag, "_game_over"}, {31'd0, game_over}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    resetn  = 1'b0;
    start   = 1'b0;
    pad_hit = 3'b000;
    #12;
    check_all_zero("reset");
    @(posedge clock);
    #1;
    resetn = 1'b1;
    step();

    // Start: 8 cycles of GAP, one ARM cycle, then WAIT.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("gap_len", {29'd0, state_out}, 32'd1);
      step();
    end
    check("arm_state", {29'd0, state_out}, 32'd2);
    check("arm_light", {29'd0, light_onehot}, 32'd0);
    step();
    check("wait_state", {29'd0, state_out}, 32'd3);
    check("wait_onehot", {31'd0, $onehot(light_onehot)}, 32'd1);
    check("wait_busy", {31'd0, busy}, 32'd1);

    // Correct pad.
    pad_hit = light_onehot;
    step();
    pad_hit = 3'b000;
    check("hit_state", {29'd0, state_out}, 32'd4);
    check("hit_score", {16'd0, score}, 32'd1);
    check("hit_light", {29'd0, light_onehot}, 32'd0);
    step();
    check("hit_to_gap", {29'd0, state_out}, 32'd1);

    // Correct and wrong pad in the same cycle counts as a hit.
    run_to_wait();
    pad_hit = light_onehot | rot(light_onehot);
    step();
    pad_hit = 3'b000;
    check("both_state", {29'd0, state_out}, 32'd4);
    check("both_score", {16'd0, score}, 32'd2);

    // Wrong pad only.
    run_to_wait();
    pad_hit = rot(light_onehot);
    step();
    pad_hit = 3'b000;
    check("wrong_state", {29'd0, state_out}, 32'd5);
    check("wrong_misses", {28'd0, misses}, 32'd1);
    check("wrong_light", {29'd0, light_onehot}, 32'd0);
    step();
    check("miss_to_gap", {29'd0, state_out}, 32'd1);

    // Timeout after exactly 20 WAIT cycles.
    run_to_wait();
    for (int i = 0; i < 19; i++) begin
      check("wait_hold", {29'd0, state_out}, 32'd3);
      step();
    end
    step();
    check("timeout_state", {29'd0, state_out}, 32'd5);
    check("timeout_misses", {28'd0, misses}, 32'd2);
    step();
    check("timeout_to_gap", {29'd0, state_out}, 32'd1);

    // Third miss ends the game.
    run_to_wait();
    repeat (20) step();
    check("miss3_state", {29'd0, state_out}, 32'd5);
    check("miss3_misses", {28'd0, misses}, 32'd3);
    step();
    check("over_state", {29'd0, state_out}, 32'd6);
    check("over_flag", {31'd0, game_over}, 32'd1);
    check("over_busy", {31'd0, busy}, 32'd0);
    check("over_light", {29'd0, light_onehot}, 32'd0);
    check("over_score", {16'd0, score}, 32'd2);
    step();
    check("over_hold", {29'd0, state_out}, 32'd6);

    // Restart from OVER clears the counters.
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_state", {29'd0, state_out}, 32'd1);
    check("restart_score", {16'd0, score}, 32'd0);
    check("restart_misses", {28'd0, misses}, 32'd0);
    check("restart_over", {31'd0, game_over}, 32'd0);

    // A pad held through GAP delays ARM until release.
    pad_hit = 3'b001;
    repeat (12) step();
    check("gap_held", {29'd0, state_out}, 32'd1);
    pad_hit = 3'b000;
    step();
    check("release_arm", {29'd0, state_out}, 32'd2);
    step();
    check("release_wait", {29'd0, state_out}, 32'd3);
    prev_light = light_onehot;
    pad_hit = light_onehot;
    step();
    pad_hit = 3'b000;
    exp_score = 16'd1;
    check("held_hit_score", {16'd0, score}, {16'd0, exp_score});

    // 50 rounds: one-hot light, never the same pad twice in a row.
    for (int r = 0; r < 50; r++) begin
      run_to_wait();
      check("round_onehot", {31'd0, $onehot(light_onehot)}, 32'd1);
      check("round_no_repeat", {31'd0, (light_onehot != prev_light)}, 32'd1);
      prev_light = light_onehot;
      pad_hit = light_onehot;
      step();
      pad_hit = 3'b000;
      exp_score = exp_score + 16'd1;
      check("round_score", {16'd0, score}, {16'd0, exp_score});
    end

    // Score saturation.
    run_to_wait();
    force dut.score = 16'hFFFF;
    #1;
    release dut.score;
    #1;
    pad_hit = light_onehot;
    step();
    pad_hit = 3'b000;
    check("sat_state", {29'd0, state_out}, 32'd4);
    check("sat_score", {16'd0, score}, 32'h0000FFFF);
    step();
    check("sat_hold", {16'd0, score}, 32'h0000FFFF);

    // Asynchronous reset in the middle of WAIT.
    run_to_wait();
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero("async_reset");
    #20;
    resetn = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
